// File: rtl/pmp_pkg.sv
// pmp_pkg: shared widths, FIFO entry type and register-select encoding
// for the PMP feeder lane.
package pmp_pkg;

  localparam int PMP_DATA_W = 64;
  localparam int PMP_CTRL_W = 16;

  // One queued PMM input beat.
  typedef struct packed {
    logic [PMP_DATA_W-1:0] data;
    logic [PMP_CTRL_W-1:0] control;
  } pmp_entry_t;

  // Register write targets; select value 3 is unused and ignored.
  typedef enum logic [1:0] {
    WSEL_DATA_LO     = 2'd0,
    WSEL_DATA_HI     = 2'd1,
    WSEL_CTRL_COMMIT = 2'd2
  } pmp_wsel_e;

endpackage

// File: rtl/pmp_fifo.sv
// pmp_fifo: first-word-fall-through FIFO of pmp_entry_t. The head entry is
// visible combinationally from the storage slot at rd_ptr. When the FIFO is
// empty the head is forced to zero. An explicit entry count tells full from
// empty. clear empties the FIFO and overrides a push or pop in the same cycle.
module pmp_fifo
  import pmp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   push,
  input  pmp_entry_t             push_entry,
  input  logic                   pop,
  output pmp_entry_t             head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  pmp_entry_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push_ok, pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
  assign push_ok = push & (~full | pop) & ~clear;
  assign pop_ok  = pop & ~empty & ~clear;
  assign head    = empty ? '0 : mem[rd_ptr];

  // Storage write. There is no reset because the empty mask hides stale slots.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_entry;
  end

  // Pointer and occupancy update. The pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pmp_feeder.sv
// pmp_feeder: per-lane PMM input feeder. It stages a 64-bit data word from two
// 32-bit register writes. A control write commits {data, control} into an FWFT
// FIFO, and the FIFO head drives the PMM through a valid/ready handshake.
// The feeder also tracks a sticky overflow flag for dropped commits and keeps a
// saturating count of rising edges on accepted_status.
// Optional build macro: PMP_FEEDER_FLUSH_EN adds a synchronous flush input.
module pmp_feeder
  import pmp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [1:0]             wr_sel,
  input  logic [31:0]            wr_data,
  input  logic                   clr_status,
`ifdef PMP_FEEDER_FLUSH_EN
  input  logic                   flush,
`endif
  output logic [PMP_DATA_W-1:0]  inp_data,
  output logic [PMP_CTRL_W-1:0]  inp_control,
  output logic                   data_valid,
  input  logic                   ready_status,
  input  logic                   accepted_status,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   full,
  output logic                   overflow,
  output logic [CNT_W-1:0]       match_count
);

  logic [PMP_DATA_W-1:0] stage_data;
  logic                  commit, pop, empty, flush_i, acc_q;
  pmp_entry_t            push_entry, head;

`ifdef PMP_FEEDER_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  assign commit      = wr_en && (wr_sel == WSEL_CTRL_COMMIT);
  assign data_valid  = ~empty;
  assign pop         = data_valid & ready_status;
  assign push_entry  = '{data: stage_data, control: wr_data[PMP_CTRL_W-1:0]};
  assign inp_data    = head.data;
  assign inp_control = head.control;

  pmp_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (flush_i),
    .push       (commit),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (fifo_count),
    .full       (full),
    .empty      (empty)
  );

  // Staging halves are written independently and persist across commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_data <= '0;
    end else if (wr_en) begin
      if (wr_sel == WSEL_DATA_LO) stage_data[31:0]  <= wr_data;
      if (wr_sel == WSEL_DATA_HI) stage_data[63:32] <= wr_data;
    end
  end

  // Sticky overflow: set on a commit dropped at full with no pop in the same
  // cycle; software clear takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    overflow <= 1'b0;
    else if (clr_status)                           overflow <= 1'b0;
    else if (commit && full && !pop && !flush_i)   overflow <= 1'b1;
  end

  // Rising-edge counter on accepted_status that saturates; a clear in the same cycle wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= 1'b0;
      match_count <= '0;
    end else begin
      acc_q <= accepted_status;
      if (clr_status)
        match_count <= '0;
      else if (accepted_status && !acc_q && (match_count != '1))
        match_count <= match_count + 1'b1;
    end
  end

endmodule
